// File: rtl/psum_wb_accum_pkg.sv
// Shared types and defaults for the partial-sum write-back path.
package psum_wb_accum_pkg;

  localparam int unsigned PSUM_W_DEF    = 10;
  localparam int unsigned ACC_W_DEF     = 16;
  localparam int unsigned NUM_TERMS_DEF = 5;
  localparam int unsigned SHIFT_DEF     = 0;
  localparam int unsigned OUT_W_DEF     = 8;
  localparam int unsigned ADDR_W_DEF    = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Counter width that stays >= 1 even for a single-term pixel.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_wb_accum_quantize.sv
// Combinational shift + optional ReLU + signed saturation to OUT_W bits.
module psum_wb_accum_quantize
  import psum_wb_accum_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned SHIFT = SHIFT_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] sum_i,
  input  logic             relu_en_i,
  output logic [OUT_W-1:0] data_c_o,
  output logic             sat_c_o
);

  localparam int MAX_I = (2 ** (OUT_W - 1)) - 1;
  localparam int MIN_I = -(2 ** (OUT_W - 1));
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(MIN_I);

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] y;

  // ReLU is not a clamp, so it never raises the saturation flag.
  always_comb begin
    shifted  = $signed(sum_i) >>> SHIFT;
    y        = shifted;
    sat_c_o  = 1'b0;
    if (relu_en_i && shifted[ACC_W-1]) begin
      y = '0;
    end
    data_c_o = y[OUT_W-1:0];
    if (y > MAX_V) begin
      data_c_o = MAX_V[OUT_W-1:0];
      sat_c_o  = 1'b1;
    end else if (y < MIN_V) begin
      data_c_o = MIN_V[OUT_W-1:0];
      sat_c_o  = 1'b1;
    end
  end

endmodule

// File: rtl/psum_wb_accum.sv
// Write-back accumulator: sums NUM_TERMS groupsum beats per pixel, quantizes,
// and writes each pixel to the ofmap buffer at an incrementing address.
module psum_wb_accum
  import psum_wb_accum_pkg::*;
#(
  parameter int unsigned PSUM_W    = PSUM_W_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned NUM_TERMS = NUM_TERMS_DEF,
  parameter int unsigned SHIFT     = SHIFT_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] num_pix_i,
  input  logic              relu_en_i,
  input  logic [PSUM_W-1:0] psum_i,
  input  logic              psum_valid_i,
  output logic              ofmap_we_o,
  output logic [ADDR_W-1:0] ofmap_addr_o,
  output logic [OUT_W-1:0]  ofmap_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sat_flag_o
);

  localparam int unsigned TERM_W = cnt_w(NUM_TERMS);
  localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(NUM_TERMS - 1);

  state_e            state_q,   state_d;
  logic [ACC_W-1:0]  acc_q,     acc_d;
  logic [TERM_W-1:0] term_q,    term_d;
  logic [ADDR_W-1:0] pix_q,     pix_d;
  logic [ADDR_W-1:0] num_pix_q, num_pix_d;
  logic              relu_q,    relu_d;
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [OUT_W-1:0]  data_q,    data_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              sat_q,     sat_d;

  logic [ACC_W-1:0]  psum_ext_c;
  logic [ACC_W-1:0]  sum_c;
  logic [OUT_W-1:0]  q_data_c;
  logic              q_sat_c;

  // Term 0 loads rather than adds, so no separate accumulator clear is needed.
  assign psum_ext_c = ACC_W'($signed(psum_i));
  assign sum_c      = ((term_q == '0) ? '0 : acc_q) + psum_ext_c;

  psum_wb_accum_quantize #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_quant (
    .sum_i     (sum_c),
    .relu_en_i (relu_q),
    .data_c_o  (q_data_c),
    .sat_c_o   (q_sat_c)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    term_d    = term_q;
    pix_d     = pix_q;
    num_pix_d = num_pix_q;
    relu_d    = relu_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    sat_d     = sat_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pix_d     = '0;
          term_d    = '0;
          sat_d     = 1'b0;
          num_pix_d = num_pix_i;
          relu_d    = relu_en_i;
          state_d   = (num_pix_i == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        // A start mid-frame restarts it and wins over a coincident final beat.
        if (start_i) begin
          pix_d     = '0;
          term_d    = '0;
          sat_d     = 1'b0;
          num_pix_d = num_pix_i;
          relu_d    = relu_en_i;
        end else if (psum_valid_i) begin
          acc_d = sum_c;
          if (term_q == LAST_TERM) begin
            term_d = '0;
            we_d   = 1'b1;
            addr_d = pix_q;
            data_d = q_data_c;
            sat_d  = sat_q | q_sat_c;
            pix_d  = pix_q + ADDR_W'(1);
            if (pix_q == num_pix_q - ADDR_W'(1)) begin
              state_d = S_FIN;
            end
          end else begin
            term_d = term_q + TERM_W'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      term_q    <= '0;
      pix_q     <= '0;
      num_pix_q <= '0;
      relu_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      term_q    <= term_d;
      pix_q     <= pix_d;
      num_pix_q <= num_pix_d;
      relu_q    <= relu_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
    end
  end

  assign ofmap_we_o   = we_q;
  assign ofmap_addr_o = addr_q;
  assign ofmap_data_o = data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign sat_flag_o   = sat_q;

endmodule

// File: tb/tb_psum_wb_accum.sv
// Directed bench for psum_wb_accum with NUM_TERMS=5, SHIFT=0, OUT_W=8.
module tb_psum_wb_accum;

  localparam int unsigned PSUM_W = 10;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [ADDR_W-1:0] num_pix_i;
  logic              relu_en_i;
  logic [PSUM_W-1:0] psum_i;
  logic              psum_valid_i;
  logic              ofmap_we_o;
  logic [ADDR_W-1:0] ofmap_addr_o;
  logic [OUT_W-1:0]  ofmap_data_o;
  logic              busy_o;
  logic              done_o;
  logic              sat_flag_o;

  int checks = 0;
  int errors = 0;

  int wr_addr[$];
  int wr_data[$];
  int run_addr[$];
  int run_data[$];

  psum_wb_accum dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .num_pix_i    (num_pix_i),
    .relu_en_i    (relu_en_i),
    .psum_i       (psum_i),
    .psum_valid_i (psum_valid_i),
    .ofmap_we_o   (ofmap_we_o),
    .ofmap_addr_o (ofmap_addr_o),
    .ofmap_data_o (ofmap_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .sat_flag_o   (sat_flag_o)
  );

  always #5 clk = ~clk;

  // Log every write away from the active edge.
  always @(negedge clk) begin
    if (rst_n && ofmap_we_o) begin
      wr_addr.push_back(int'(ofmap_addr_o));
      wr_data.push_back(int'($signed(ofmap_data_o)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int v);
    psum_valid_i = 1'b1;
    psum_i       = PSUM_W'(v);
    cyc();
    psum_valid_i = 1'b0;
  endtask

  task automatic do_start(input int np, input logic relu);
    start_i   = 1'b1;
    num_pix_i = ADDR_W'(np);
    relu_en_i = relu;
    cyc();
    start_i   = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  int vals[20] = '{1, 2, 3, 4, 5,
                   -10, -10, -10, -10, -10,
                   30, 30, 30, 30, 30,
                   -50, -20, 0, 7, 3};
  int exp_d[4] = '{15, -50, 127, -60};

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    num_pix_i    = '0;
    relu_en_i    = 1'b0;
    psum_i       = '0;
    psum_valid_i = 1'b0;
    cyc();
    cyc();
    chk("rst_we", ofmap_we_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    cyc();

    // Reset asserted mid-frame clears everything at once.
    do_start(3, 1'b0);
    chk("t1_busy", busy_o, 1);
    for (int i = 0; i < 5; i++) beat(10);
    chk("t1_we", ofmap_we_o, 1);
    chk("t1_data", $signed(ofmap_data_o), 50);
    for (int i = 0; i < 3; i++) beat(7);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_busy", busy_o, 0);
    chk("t1_async_data", $signed(ofmap_data_o), 0);
    chk("t1_async_we", ofmap_we_o, 0);
    chk("t1_async_sat", sat_flag_o, 0);
    chk("t1_async_done", done_o, 0);
    cyc();
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 5; i++) beat(9);
    cyc();
    chk("t1_nostart_writes", wr_addr.size(), 0);
    chk("t1_nostart_busy", busy_o, 0);

    // Two-pixel frame, second pixel saturates and coincides with done.
    do_start(2, 1'b0);
    beat(10); beat(20); beat(30); beat(-5); beat(5);
    chk("t2_p0_we", ofmap_we_o, 1);
    chk("t2_p0_addr", ofmap_addr_o, 0);
    chk("t2_p0_data", $signed(ofmap_data_o), 60);
    chk("t2_p0_done", done_o, 0);
    for (int i = 0; i < 5; i++) beat(100);
    chk("t2_p1_we", ofmap_we_o, 1);
    chk("t2_p1_addr", ofmap_addr_o, 1);
    chk("t2_p1_data", $signed(ofmap_data_o), 127);
    chk("t2_p1_sat", sat_flag_o, 1);
    chk("t2_p1_done", done_o, 1);
    cyc();
    chk("t2_after_done", done_o, 0);
    chk("t2_after_we", ofmap_we_o, 0);
    chk("t2_after_busy", busy_o, 0);
    chk("t2_hold_data", $signed(ofmap_data_o), 127);

    // ReLU suppresses the negative clamp; without it -200 clamps to -128.
    do_start(1, 1'b1);
    chk("t3_sat_cleared", sat_flag_o, 0);
    beat(-100); beat(-100); beat(0); beat(0); beat(0);
    chk("t3_relu_data", $signed(ofmap_data_o), 0);
    chk("t3_relu_sat", sat_flag_o, 0);
    chk("t3_relu_done", done_o, 1);
    cyc();
    do_start(1, 1'b0);
    beat(-100); beat(-100); beat(0); beat(0); beat(0);
    chk("t3_norelu_data", $signed(ofmap_data_o), -128);
    chk("t3_norelu_sat", sat_flag_o, 1);
    cyc();

    // Back-to-back beats vs. random gaps must produce the same writes.
    clear_log();
    do_start(4, 1'b0);
    for (int k = 0; k < 20; k++) begin
      psum_valid_i = 1'b1;
      psum_i       = PSUM_W'(vals[k]);
      cyc();
    end
    psum_valid_i = 1'b0;
    cyc(); cyc(); cyc();
    chk("t4_b2b_count", wr_addr.size(), 4);
    chk("t4_b2b_busy", busy_o, 0);
    run_addr = wr_addr;
    run_data = wr_data;
    for (int p = 0; p < 4 && p < run_addr.size(); p++) begin
      chk($sformatf("t4_b2b_addr%0d", p), run_addr[p], p);
      chk($sformatf("t4_b2b_data%0d", p), run_data[p], exp_d[p]);
    end
    clear_log();
    do_start(4, 1'b0);
    for (int k = 0; k < 20; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        psum_valid_i = 1'b0;
        psum_i       = PSUM_W'(77);
        cyc();
      end
      beat(vals[k]);
    end
    cyc(); cyc(); cyc();
    chk("t4_gap_count", wr_addr.size(), 4);
    for (int p = 0; p < 4 && p < wr_addr.size(); p++) begin
      chk($sformatf("t4_gap_addr%0d", p), wr_addr[p], p);
      chk($sformatf("t4_gap_data%0d", p), wr_data[p], exp_d[p]);
    end
    chk("t4_sat", sat_flag_o, 1);

    // Restart mid-pixel discards the partial sum and clears the sticky flag.
    clear_log();
    do_start(2, 1'b0);
    chk("t5_sat_cleared", sat_flag_o, 0);
    beat(50); beat(50); beat(50);
    do_start(1, 1'b0);
    chk("t5_restart_busy", busy_o, 1);
    chk("t5_abort_nowrite", wr_addr.size(), 0);
    for (int i = 0; i < 5; i++) beat(1);
    chk("t5_we", ofmap_we_o, 1);
    chk("t5_addr", ofmap_addr_o, 0);
    chk("t5_data", $signed(ofmap_data_o), 5);
    chk("t5_done", done_o, 1);
    cyc();

    // Start coincident with a final beat drops that pixel.
    do_start(1, 1'b0);
    for (int i = 0; i < 4; i++) beat(3);
    start_i      = 1'b1;
    num_pix_i    = ADDR_W'(1);
    psum_valid_i = 1'b1;
    psum_i       = PSUM_W'(3);
    cyc();
    start_i      = 1'b0;
    psum_valid_i = 1'b0;
    chk("t5b_dropped_we", ofmap_we_o, 0);
    chk("t5b_busy", busy_o, 1);
    for (int i = 0; i < 5; i++) beat(2);
    chk("t5b_data", $signed(ofmap_data_o), 10);
    chk("t5b_addr", ofmap_addr_o, 0);
    cyc();

    // Empty frame: one-cycle done, never busy, no write.
    clear_log();
    do_start(0, 1'b0);
    chk("t6_done", done_o, 1);
    chk("t6_busy", busy_o, 0);
    chk("t6_we", ofmap_we_o, 0);
    cyc();
    chk("t6_done_end", done_o, 0);
    chk("t6_busy_end", busy_o, 0);
    chk("t6_nowrite", wr_addr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
